sdc_wr_blk_seq: RTL and testbench
=================================

# sdc_wr_blk_seq

Multi-block write sequencer for the SD card 1-bit data path. It launches the block transmitter once per 512-byte block and drives the system-memory word address consumed on each new-data strobe. Between blocks it waits out the card's DAT0 write-busy, with a timeout. It sits between the SD host command FSM (after CMD24/CMD25 is accepted) and the 1-bit data sender.

## Interface
Parameters:
- GAP_CLKS, 8, idle sd_clk cycles between busy release and next block launch (min 2)
- TO_W, 24, width of busy-timeout counter
- BUSY_TO, 24'hFF_FFFF, sd_clk cycles allowed in write-busy before error

Ports:
- sd_clk  in  1  clock; all logic posedge
- reset  in  1  synchronous, active-high
- wr_req_strb  in  1  one-cycle request; ignored unless idle
- num_blks  in  16  blocks to write; captured on wr_req_strb; 0 treated as 1
- base_addr  in  16  first 64-bit word address; captured on wr_req_strb
- abort_strb  in  1  stop after current block's busy phase
- strt_snd_data_strb  out  1  one-cycle launch to sender
- new_dat_strb  in  1  sender fetched a word
- dat_tf_done  in  1  sender finished block bits
- wr_busy  in  1  card write-busy flag from sender
- sm_rd_addr  out  16  word address to system memory
- seq_busy  out  1  high from request capture until done/error
- blks_done  out  16  completed-block count
- wr_done_strb  out  1  one-cycle, all blocks written
- wr_err_strb  out  1  one-cycle, error terminated sequence
- err_code  out  2  0 none, 1 busy timeout, 2 word-count mismatch, 3 busy never asserted

## Operation
- States: IDLE, LAUNCH, SEND, BSY_RISE, BSY_FALL, GAP, FIN.
- IDLE: on wr_req_strb, capture num_blks, base_addr; sm_rd_addr<=base_addr; blks_done<=0; err_code<=0; seq_busy<=1; go LAUNCH.
- LAUNCH: pulse strt_snd_data_strb one cycle; clear word counter; go SEND.
- SEND: each new_dat_strb increments sm_rd_addr by 1 (wraps 16'hFFFF->0) and word counter. On dat_tf_done, the word counter must equal 63; otherwise err_code<=2, go FIN. Otherwise, the address advances once more (block's 64th word consumed), then go BSY_RISE.
- BSY_RISE: wait for wr_busy=1, then go BSY_FALL; if not seen within 4 cycles, err_code<=3, go FIN.
- BSY_FALL: count cycles; on wr_busy=0, blks_done++. If blks_done+1==num_blks or abort is latched, go FIN; else go GAP. If the counter reaches BUSY_TO, err_code<=1, go FIN.
- GAP: count GAP_CLKS, then go LAUNCH.
- FIN: pulse wr_done_strb if err_code==0 and no abort, else wr_err_strb (abort with no error: err strobe, code 0); seq_busy<=0; go IDLE.
- abort_strb latched in any non-IDLE state; cleared on entry to IDLE.

## Timing
- Reset values: strt_snd_data_strb 0, sm_rd_addr 0, seq_busy 0, blks_done 0, wr_done_strb 0, wr_err_strb 0, err_code 0; state IDLE.
- wr_req_strb at cycle t -> strt_snd_data_strb at t+2.
- sm_rd_addr changes the cycle after new_dat_strb; holds ≥60 cycles before the next fetch.
- Memory must present data for sm_rd_addr within 2 cycles; sender samples word 0 two cycles after launch.
- wr_req_strb while seq_busy=1: ignored.
- Simultaneous dat_tf_done and new_dat_strb: count the strobe first, then check.
- Reset mid-operation: immediate IDLE, all outputs to reset values, no done/err strobe.

## Structure
- Shared package sdc_pkg: state encoding, err_code constants, WORDS_PER_BLK=64.
- One sub-module is natural: the existing CounterSeq instance for the GAP and BSY_RISE windows. The busy timeout is an inline TO_W counter.

## Test plan
- num_blks=1, base_addr=16'h0100, sender model: one launch; sm_rd_addr ends 16'h0140; blks_done=1; wr_done_strb once.
- num_blks=3, base 16'hFFF0: three launches, each ≥GAP_CLKS after busy release; address wraps and ends 16'h00B0.
- Busy held high beyond BUSY_TO=24'h100: wr_err_strb, err_code=1, blks_done=0.
- Sender emits only 62 new_dat_strb: err_code=2 at dat_tf_done.
- abort_strb during block 2 of 5: block 2 completes, blks_done=2, wr_err_strb, err_code=0.
- Reset asserted in BSY_FALL: outputs at reset values next cycle; a new wr_req_strb is then accepted normally.

Source files
------------

// File: rtl/sdc_pkg.sv
// Shared definitions for the SD card data-path sequencers: state encoding,
// error codes and block geometry.
`timescale 1ns/1ps
package sdc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LAUNCH   = 3'd1,
    ST_SEND     = 3'd2,
    ST_BSY_RISE = 3'd3,
    ST_BSY_FALL = 3'd4,
    ST_GAP      = 3'd5,
    ST_FIN      = 3'd6
  } wr_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BUSY_TO  = 2'd1,
    ERR_WORD_CNT = 2'd2,
    ERR_NO_BUSY  = 2'd3
  } wr_err_e;

  localparam int WORDS_PER_BLK = 64;
  // Cycles the card gets to raise DAT0 busy after the block's last bit.
  localparam int BSY_RISE_CLKS = 4;

endpackage

// File: rtl/sdc_wr_blk_seq_counter_seq.sv
// Small window counter: clears on clr, counts while en until it reaches last,
// then holds and flags hit.
`timescale 1ns/1ps
module counter_seq #(
  parameter int W = 4
) (
  input  logic         sd_clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         hit
);

  logic [W-1:0] cnt;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge sd_clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && !hit) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == last);

endmodule

// File: rtl/sdc_wr_blk_seq.sv
// Multi-block write sequencer: launches the 1-bit sender once per 512-byte
// block, walks the memory word address and waits out DAT0 write-busy.
`timescale 1ns/1ps
module sdc_wr_blk_seq
  import sdc_pkg::*;
#(
  parameter int              GAP_CLKS = 8,
  parameter int              TO_W     = 24,
  parameter logic [TO_W-1:0] BUSY_TO  = 24'hFF_FFFF
) (
  input  logic        sd_clk,
  input  logic        reset,
  input  logic        wr_req_strb,
  input  logic [15:0] num_blks,
  input  logic [15:0] base_addr,
  input  logic        abort_strb,
  output logic        strt_snd_data_strb,
  input  logic        new_dat_strb,
  input  logic        dat_tf_done,
  input  logic        wr_busy,
  output logic [15:0] sm_rd_addr,
  output logic        seq_busy,
  output logic [15:0] blks_done,
  output logic        wr_done_strb,
  output logic        wr_err_strb,
  output logic [1:0]  err_code
);

  localparam int WIN_MAX = (GAP_CLKS > BSY_RISE_CLKS) ? GAP_CLKS : BSY_RISE_CLKS;
  localparam int WIN_W   = $clog2(WIN_MAX) + 1;
  localparam logic [WIN_W-1:0] GAP_LAST  = WIN_W'(GAP_CLKS - 1);
  localparam logic [WIN_W-1:0] RISE_LAST = WIN_W'(BSY_RISE_CLKS - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = BUSY_TO - TO_W'(1);
  localparam logic [7:0]       WORD_LAST = 8'(WORDS_PER_BLK - 1);

  wr_state_e        state, state_nxt;
  logic [15:0]      num_eff;
  logic [7:0]       word_cnt;
  logic [7:0]       word_cnt_eff;
  logic             word_ok;
  logic [1:0]       addr_inc;
  logic [TO_W-1:0]  to_cnt;
  logic             to_hit;
  logic             abort_lat;
  logic             last_blk;
  logic             win_clr;
  logic             win_hit;
  logic [WIN_W-1:0] win_last;

  // A strobe arriving with dat_tf_done is counted before the word check.
  assign word_cnt_eff = word_cnt + {7'd0, new_dat_strb};
  assign word_ok      = (word_cnt_eff == WORD_LAST);
  assign addr_inc     = {1'b0, new_dat_strb} + {1'b0, dat_tf_done && word_ok};
  assign to_hit       = (to_cnt == TO_LAST);
  assign last_blk     = (({1'b0, blks_done} + 17'd1) == {1'b0, num_eff});

  // One counter serves both the busy-rise window and the inter-block gap.
  assign win_clr  = (state != ST_GAP) && (state != ST_BSY_RISE);
  assign win_last = (state == ST_GAP) ? GAP_LAST : RISE_LAST;

  counter_seq #(.W(WIN_W)) u_win_cnt (
    .sd_clk (sd_clk),
    .reset  (reset),
    .clr    (win_clr),
    .en     (!win_clr),
    .last   (win_last),
    .hit    (win_hit)
  );

  always_ff @(posedge sd_clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (wr_req_strb) state_nxt = ST_LAUNCH;
      ST_LAUNCH:   state_nxt = ST_SEND;
      ST_SEND:     if (dat_tf_done) state_nxt = word_ok ? ST_BSY_RISE : ST_FIN;
      ST_BSY_RISE: begin
        if (wr_busy)      state_nxt = ST_BSY_FALL;
        else if (win_hit) state_nxt = ST_FIN;
      end
      ST_BSY_FALL: begin
        if (!wr_busy)    state_nxt = (last_blk || abort_lat) ? ST_FIN : ST_GAP;
        else if (to_hit) state_nxt = ST_FIN;
      end
      ST_GAP:      if (win_hit) state_nxt = ST_LAUNCH;
      ST_FIN:      state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sd_clk) begin
    if (reset || state != ST_BSY_FALL) begin
      to_cnt <= '0;
    end else if (!to_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge sd_clk) begin
    if (reset) begin
      strt_snd_data_strb <= 1'b0;
      sm_rd_addr         <= '0;
      seq_busy           <= 1'b0;
      blks_done          <= '0;
      wr_done_strb       <= 1'b0;
      wr_err_strb        <= 1'b0;
      err_code           <= ERR_NONE;
      num_eff            <= 16'd1;
      word_cnt           <= '0;
      abort_lat          <= 1'b0;
    end else begin
      strt_snd_data_strb <= (state == ST_LAUNCH);
      wr_done_strb       <= 1'b0;
      wr_err_strb        <= 1'b0;
      if (state != ST_IDLE && abort_strb) abort_lat <= 1'b1;

      case (state)
        ST_IDLE: begin
          abort_lat <= 1'b0;
          if (wr_req_strb) begin
            num_eff    <= (num_blks == 16'd0) ? 16'd1 : num_blks;
            sm_rd_addr <= base_addr;
            blks_done  <= '0;
            err_code   <= ERR_NONE;
            seq_busy   <= 1'b1;
          end
        end
        ST_LAUNCH: word_cnt <= '0;
        ST_SEND: begin
          sm_rd_addr <= sm_rd_addr + {14'd0, addr_inc};
          word_cnt   <= word_cnt_eff;
          if (dat_tf_done && !word_ok) err_code <= ERR_WORD_CNT;
        end
        ST_BSY_RISE: if (!wr_busy && win_hit) err_code <= ERR_NO_BUSY;
        ST_BSY_FALL: begin
          if (!wr_busy)    blks_done <= blks_done + 16'd1;
          else if (to_hit) err_code  <= ERR_BUSY_TO;
        end
        ST_FIN: begin
          seq_busy  <= 1'b0;
          abort_lat <= 1'b0;
          if (err_code == ERR_NONE && !abort_lat) wr_done_strb <= 1'b1;
          else                                    wr_err_strb  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_wr_blk_seq.sv
// Directed bench for sdc_wr_blk_seq with a behavioural 1-bit sender and card
// busy model; expected values are hand-computed per scenario.
`timescale 1ns/1ps
module tb_sdc_wr_blk_seq;

  localparam int GAP_CLKS = 8;

  logic        sd_clk = 1'b0;
  logic        reset;
  logic        wr_req_strb;
  logic [15:0] num_blks;
  logic [15:0] base_addr;
  logic        abort_strb;
  logic        strt_snd_data_strb;
  logic        new_dat_strb;
  logic        dat_tf_done;
  logic        wr_busy;
  logic [15:0] sm_rd_addr;
  logic        seq_busy;
  logic [15:0] blks_done;
  logic        wr_done_strb;
  logic        wr_err_strb;
  logic [1:0]  err_code;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int launch_cnt = 0, done_cnt = 0, err_cnt = 0;
  int rel_cyc = -1, min_gap = 1000;
  int l0, d0, e0, waited;

  sdc_wr_blk_seq #(
    .GAP_CLKS (GAP_CLKS),
    .TO_W     (24),
    .BUSY_TO  (24'h100)
  ) dut (
    .sd_clk             (sd_clk),
    .reset              (reset),
    .wr_req_strb        (wr_req_strb),
    .num_blks           (num_blks),
    .base_addr          (base_addr),
    .abort_strb         (abort_strb),
    .strt_snd_data_strb (strt_snd_data_strb),
    .new_dat_strb       (new_dat_strb),
    .dat_tf_done        (dat_tf_done),
    .wr_busy            (wr_busy),
    .sm_rd_addr         (sm_rd_addr),
    .seq_busy           (seq_busy),
    .blks_done          (blks_done),
    .wr_done_strb       (wr_done_strb),
    .wr_err_strb        (wr_err_strb),
    .err_code           (err_code)
  );

  always #5 sd_clk = ~sd_clk;
  always @(posedge sd_clk) cyc <= cyc + 1;

  always @(negedge sd_clk) begin
    if (strt_snd_data_strb) begin
      launch_cnt++;
      if (rel_cyc >= 0 && (cyc - rel_cyc) < min_gap) min_gap = cyc - rel_cyc;
    end
    if (wr_done_strb) done_cnt++;
    if (wr_err_strb)  err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic req(input logic [15:0] n, input logic [15:0] base);
    @(negedge sd_clk);
    wr_req_strb = 1'b1;
    num_blks    = n;
    base_addr   = base;
    @(negedge sd_clk);
    wr_req_strb = 1'b0;
  endtask

  task automatic wait_launch(output int polls);
    polls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sd_clk);
      polls++;
      if (strt_snd_data_strb) return;
    end
    check("launch_timeout", 0, 1);
  endtask

  // Sender model: n fetch strobes spaced two cycles apart, then block done;
  // with merge the last strobe coincides with dat_tf_done.
  task automatic send_words(input int n, input bit merge);
    for (int i = 0; i < n; i++) begin
      new_dat_strb = 1'b1;
      if (merge && i == n - 1) dat_tf_done = 1'b1;
      @(negedge sd_clk);
      new_dat_strb = 1'b0;
      dat_tf_done  = 1'b0;
      if (i != n - 1) @(negedge sd_clk);
    end
    if (!merge) begin
      dat_tf_done = 1'b1;
      @(negedge sd_clk);
      dat_tf_done = 1'b0;
    end
  endtask

  task automatic busy_phase(input int n);
    wr_busy = 1'b1;
    repeat (n) @(negedge sd_clk);
    wr_busy = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sd_clk);
      if (!seq_busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("idle_timeout", 0, 1);
    @(negedge sd_clk);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; wr_req_strb = 1'b0; num_blks = '0; base_addr = '0;
    abort_strb = 1'b0; new_dat_strb = 1'b0; dat_tf_done = 1'b0; wr_busy = 1'b0;
    repeat (4) @(negedge sd_clk);
    reset = 1'b0;
    @(negedge sd_clk);
    check("rst_strt",  strt_snd_data_strb, 0);
    check("rst_addr",  sm_rd_addr, 0);
    check("rst_busy",  seq_busy, 0);
    check("rst_blks",  blks_done, 0);
    check("rst_done",  wr_done_strb, 0);
    check("rst_err",   wr_err_strb, 0);
    check("rst_code",  err_code, 0);

    // Single block, last fetch merged with dat_tf_done.
    l0 = launch_cnt; d0 = done_cnt; e0 = err_cnt;
    req(16'd1, 16'h0100);
    check("t1_strt_early", strt_snd_data_strb, 0);
    check("t1_seq_busy",   seq_busy, 1);
    wait_launch(waited);
    check("t1_strt_lat",   waited, 1);
    check("t1_addr_start", sm_rd_addr, 16'h0100);
    send_words(63, 1'b1);
    busy_phase(20);
    wait_idle();
    check("t1_addr_end", sm_rd_addr, 16'h0140);
    check("t1_blks",     blks_done, 1);
    check("t1_launches", launch_cnt - l0, 1);
    check("t1_done",     done_cnt - d0, 1);
    check("t1_err",      err_cnt - e0, 0);
    check("t1_code",     err_code, 0);

    // Three blocks with address wrap; a stray request mid-run is ignored.
    l0 = launch_cnt; d0 = done_cnt; e0 = err_cnt;
    rel_cyc = -1; min_gap = 1000;
    req(16'd3, 16'hFFF0);
    for (int b = 0; b < 3; b++) begin
      wait_launch(waited);
      if (b == 0) begin
        wr_req_strb = 1'b1; num_blks = 16'd7; base_addr = 16'h1234;
        @(negedge sd_clk);
        wr_req_strb = 1'b0;
      end
      send_words(63, 1'b0);
      busy_phase(20);
    end
    wait_idle();
    check("t2_launches", launch_cnt - l0, 3);
    check("t2_addr_end", sm_rd_addr, 16'h00B0);
    check("t2_blks",     blks_done, 3);
    check("t2_done",     done_cnt - d0, 1);
    check("t2_gap_ok",   min_gap >= GAP_CLKS, 1);

    // Busy held past BUSY_TO.
    d0 = done_cnt; e0 = err_cnt;
    req(16'd1, 16'h0200);
    wait_launch(waited);
    send_words(63, 1'b0);
    busy_phase(300);
    wait_idle();
    check("t3_err",  err_cnt - e0, 1);
    check("t3_done", done_cnt - d0, 0);
    check("t3_code", err_code, 1);
    check("t3_blks", blks_done, 0);

    // Sender delivers only 62 fetch strobes.
    e0 = err_cnt;
    req(16'd1, 16'h0300);
    wait_launch(waited);
    send_words(62, 1'b0);
    wait_idle();
    check("t4_err",  err_cnt - e0, 1);
    check("t4_code", err_code, 2);
    check("t4_addr", sm_rd_addr, 16'h033E);
    check("t4_blks", blks_done, 0);

    // Card never raises busy.
    e0 = err_cnt;
    req(16'd1, 16'h0700);
    wait_launch(waited);
    send_words(63, 1'b0);
    wait_idle();
    check("t5_err",  err_cnt - e0, 1);
    check("t5_code", err_code, 3);
    check("t5_addr", sm_rd_addr, 16'h0740);

    // Abort during block 2 of 5.
    l0 = launch_cnt; d0 = done_cnt; e0 = err_cnt;
    req(16'd5, 16'h0400);
    for (int b = 0; b < 2; b++) begin
      wait_launch(waited);
      if (b == 1) begin
        abort_strb = 1'b1;
        @(negedge sd_clk);
        abort_strb = 1'b0;
      end
      send_words(63, 1'b0);
      busy_phase(20);
    end
    wait_idle();
    check("t6_launches", launch_cnt - l0, 2);
    check("t6_blks",     blks_done, 2);
    check("t6_err",      err_cnt - e0, 1);
    check("t6_done",     done_cnt - d0, 0);
    check("t6_code",     err_code, 0);
    check("t6_addr",     sm_rd_addr, 16'h0480);

    // Reset while waiting for busy release, then a fresh request.
    d0 = done_cnt; e0 = err_cnt;
    req(16'd2, 16'h0500);
    wait_launch(waited);
    send_words(63, 1'b0);
    wr_busy = 1'b1;
    repeat (5) @(negedge sd_clk);
    reset = 1'b1;
    @(negedge sd_clk);
    check("t7_strt", strt_snd_data_strb, 0);
    check("t7_addr", sm_rd_addr, 0);
    check("t7_busy", seq_busy, 0);
    check("t7_blks", blks_done, 0);
    check("t7_code", err_code, 0);
    reset = 1'b0;
    wr_busy = 1'b0;
    repeat (4) @(negedge sd_clk);
    check("t7_no_strobe", (done_cnt - d0) + (err_cnt - e0), 0);
    l0 = launch_cnt;
    req(16'd1, 16'h0600);
    wait_launch(waited);
    check("t7_relaunch_lat", waited, 1);
    send_words(63, 1'b0);
    busy_phase(10);
    wait_idle();
    check("t7_addr_end", sm_rd_addr, 16'h0640);
    check("t7_blks_end", blks_done, 1);
    check("t7_done",     done_cnt - d0, 1);
    check("t7_launches", launch_cnt - l0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
